// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit, one bit per cycle.
//   Radix-2 shift-add multiply and restoring divide, both on operand magnitudes.
//   Sign correction and special cases are applied in a single FIX cycle.
//   Every operation takes the same number of cycles, special cases included.
//   An operation accepted at edge 0 shows out_valid=1 after edge XLEN+1.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   request valid; in_ready = unit idle and able to accept
//   src1/src2  rs1/rs2 operands, sampled only at the acceptance edge
//   sel        one-hot op select {REMU,REM,DIVU,DIV,MULHU,MULHSU,MULH,MUL}
//   flush      kills the operation in flight and returns to IDLE
//   out_valid  result valid; out_ready = consumer accepts it
//   result     registered result, held while out_valid is high
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [7:0]      sel,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_r;
  logic [7:0]        sel_r;
  logic [XLEN-1:0]   opnd_r;    // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] acc_r;     // {partial product, multiplier} or {remainder, quotient}
  logic [CNT_W-1:0]  cnt_r;
  logic              neg_r;     // final result must be negated
  logic              div0_r;    // divisor was zero
  logic              is_mul_r;

  // Operand conditioning at acceptance.
  logic              src1_signed_s;
  logic              src2_signed_s;
  logic              neg1_s;
  logic              neg2_s;
  logic [XLEN-1:0]   mag1_s;
  logic [XLEN-1:0]   mag2_s;
  logic              is_mul_s;
  logic              res_neg_s;

  assign src1_signed_s = sel[1] | sel[2] | sel[4] | sel[6];
  assign src2_signed_s = sel[1] | sel[4] | sel[6];
  assign neg1_s        = src1_signed_s & src1[XLEN-1];
  assign neg2_s        = src2_signed_s & src2[XLEN-1];
  // The magnitude of the most negative value is its own unsigned bit pattern,
  // which is exactly what the unsigned datapath needs.
  assign mag1_s        = neg1_s ? -src1 : src1;
  assign mag2_s        = neg2_s ? -src2 : src2;
  assign is_mul_s      = |sel[3:0];
  // The remainder takes the dividend sign; everything else takes the XOR of
  // the operand signs. MUL, MULHU, DIVU and REMU see no signed operands.
  assign res_neg_s     = sel[6] ? neg1_s : (neg1_s ^ neg2_s);

  // One iteration of either algorithm.
  logic [XLEN:0]     mul_sum_s;
  logic [2*XLEN-1:0] mul_next_s;
  logic [XLEN:0]     rem_ext_s;
  logic [XLEN:0]     diff_s;
  logic [2*XLEN-1:0] div_next_s;
  logic [2*XLEN-1:0] step_next_s;

  assign mul_sum_s  = {1'b0, acc_r[2*XLEN-1:XLEN]}
                    + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
  assign mul_next_s = {mul_sum_s, acc_r[XLEN-1:1]};
  // Shift the next dividend bit into the remainder, then trial-subtract.
  // The remainder stays below the divisor, so XLEN+1 bits are enough.
  assign rem_ext_s  = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
  assign diff_s     = rem_ext_s - {1'b0, opnd_r};
  assign div_next_s = diff_s[XLEN]
                    ? {rem_ext_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0}
                    : {diff_s[XLEN-1:0],    acc_r[XLEN-2:0], 1'b1};
  assign step_next_s = is_mul_r ? mul_next_s : div_next_s;

  // Sign-corrected views of the finished datapath.
  logic [2*XLEN-1:0] prod_fix_s;
  logic [XLEN-1:0]   quot_fix_s;
  logic [XLEN-1:0]   rem_fix_s;
  logic [XLEN-1:0]   fix_s;

  assign prod_fix_s = neg_r ? -acc_r : acc_r;
  assign quot_fix_s = neg_r ? -acc_r[XLEN-1:0] : acc_r[XLEN-1:0];
  assign rem_fix_s  = neg_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];

  // Result selection in FIX. A zero divisor needs special handling for the
  // quotient only. The remainder path then already holds |src1|, and the
  // dividend sign turns that back into src1. The signed-overflow case
  // (-2^(XLEN-1) / -1) falls out of the magnitude arithmetic directly.
  always_comb begin
    fix_s = {XLEN{1'b0}};
    case (sel_r)
      8'h01:               fix_s = prod_fix_s[XLEN-1:0];
      8'h02, 8'h04, 8'h08: fix_s = prod_fix_s[2*XLEN-1:XLEN];
      8'h10, 8'h20:        fix_s = div0_r ? {XLEN{1'b1}} : quot_fix_s;
      8'h40, 8'h80:        fix_s = rem_fix_s;
      default:             fix_s = {XLEN{1'b0}};
    endcase
  end

  // Control FSM with registered handshake outputs and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= {XLEN{1'b0}};
      sel_r     <= 8'h00;
      opnd_r    <= {XLEN{1'b0}};
      acc_r     <= {(2*XLEN){1'b0}};
      cnt_r     <= {CNT_W{1'b0}};
      neg_r     <= 1'b0;
      div0_r    <= 1'b0;
      is_mul_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready && !flush) begin
            sel_r    <= sel;
            opnd_r   <= is_mul_s ? mag1_s : mag2_s;
            acc_r    <= {{XLEN{1'b0}}, (is_mul_s ? mag2_s : mag1_s)};
            cnt_r    <= CNT_INIT;
            neg_r    <= res_neg_s;
            div0_r   <= (src2 == {XLEN{1'b0}});
            is_mul_r <= is_mul_s;
            in_ready <= 1'b0;
            state_r  <= CALC;
          end else begin
            in_ready <= 1'b1;
            state_r  <= IDLE;
          end
        end
        CALC: begin
          if (flush) begin
            in_ready <= 1'b1;
            state_r  <= IDLE;
          end else begin
            acc_r <= step_next_s;
            cnt_r <= cnt_r - CNT_ONE;
            if (cnt_r == CNT_ONE) begin
              state_r <= FIX;
            end else begin
              state_r <= CALC;
            end
          end
        end
        FIX: begin
          if (flush) begin
            in_ready <= 1'b1;
            state_r  <= IDLE;
          end else begin
            result    <= fix_s;
            out_valid <= 1'b1;
            state_r   <= DONE;
          end
        end
        DONE: begin
          // flush wins over out_ready; both release the result
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= IDLE;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: directed plus randomized check of mdu_iter (XLEN=32) against
// an arithmetic reference model of the RV32M M-extension operations.
module tb_mdu_iter;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [7:0]  sel;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  mdu_iter #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src1      (src1),
    .src2      (src2),
    .sel       (sel),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: RV32M semantics computed with 64-bit integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [7:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, sp;
    logic [63:0] up;
    int          ia, ib;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if ($countones(op) != 1) return 32'h0000_0000;
    case (op)
      8'h01: begin up = {32'h0, a} * {32'h0, b}; return up[31:0]; end
      8'h02: begin sp = sa * sb; return sp[63:32]; end
      8'h04: begin sp = sa * longint'({32'h0, b}); return sp[63:32]; end
      8'h08: begin up = {32'h0, a} * {32'h0, b}; return up[63:32]; end
      8'h10: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(ia / ib);
      end
      8'h20: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        return a / b;
      end
      8'h40: begin
        if (b == 32'h0) return a;
        if (ovf) return 32'h0000_0000;
        return 32'(ia % ib);
      end
      8'h80: begin
        if (b == 32'h0) return a;
        return a % b;
      end
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait (bounded) for out_valid; checks latency and result.
  // Inputs are scrambled after acceptance to show they are not re-sampled.
  task automatic run_op(input string tag, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    int n;
    @(negedge clk);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    sel      = op;
    src1     = a;
    src2     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sel      = 8'($urandom);
    src1     = $urandom;
    src2     = $urandom;
    n = 0;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd33);
    chk({tag, "_result"}, result, exp);
  endtask

  // With out_ready high the unit must return to IDLE on the next edge.
  task automatic release_op(input string tag);
    @(posedge clk);
    #1;
    chk({tag, "_ov_low"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a, b, e;
    logic [7:0]  op;
    int          r, k, seen;

    reset     = 1'b1;
    in_valid  = 1'b0;
    src1      = 32'h0;
    src2      = 32'h0;
    sel       = 8'h00;
    flush     = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Multiply and divide with src1=0x80000000, src2=0x10
    run_op("mul",    8'h01, 32'h8000_0000, 32'h10, 32'h0000_0000); release_op("mul");
    run_op("mulh",   8'h02, 32'h8000_0000, 32'h10, 32'hFFFF_FFF8); release_op("mulh");
    run_op("mulhu",  8'h08, 32'h8000_0000, 32'h10, 32'h0000_0008); release_op("mulhu");
    run_op("mulhsu", 8'h04, 32'h8000_0000, 32'h10, 32'hFFFF_FFF8); release_op("mulhsu");
    run_op("divu",   8'h20, 32'h8000_0000, 32'h10, 32'h0800_0000); release_op("divu");
    run_op("div",    8'h10, 32'h8000_0000, 32'h10, 32'hF800_0000); release_op("div");
    run_op("rem",    8'h40, 32'h8000_0000, 32'h10, 32'h0000_0000); release_op("rem");
    run_op("remu",   8'h80, 32'h8000_0000, 32'h10, 32'h0000_0000); release_op("remu");
    run_op("div_m7", 8'h10, 32'hFFFF_FFF9, 32'h2,  32'hFFFF_FFFD); release_op("div_m7");
    run_op("rem_m7", 8'h40, 32'hFFFF_FFF9, 32'h2,  32'hFFFF_FFFF); release_op("rem_m7");

    // Divide by zero and signed overflow
    run_op("divu_z", 8'h20, 32'h7, 32'h0, 32'hFFFF_FFFF); release_op("divu_z");
    run_op("remu_z", 8'h80, 32'h7, 32'h0, 32'h0000_0007); release_op("remu_z");
    run_op("div_z",  8'h10, 32'h7, 32'h0, 32'hFFFF_FFFF); release_op("div_z");
    run_op("div_ov", 8'h10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000); release_op("div_ov");
    run_op("rem_ov", 8'h40, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000); release_op("rem_ov");

    // Non-one-hot select
    run_op("sel00", 8'h00, 32'h8000_0000, 32'h10, 32'h0); release_op("sel00");
    run_op("sel11", 8'h11, 32'h8000_0000, 32'h10, 32'h0); release_op("sel11");

    // Backpressure: result held for 10 cycles with out_ready low
    out_ready = 1'b0;
    run_op("bp", 8'h20, 32'h8000_0000, 32'h10, 32'h0800_0000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_ov_hold", {31'b0, out_valid}, 32'd1);
      chk("bp_result_hold", result, 32'h0800_0000);
      chk("bp_in_ready_low", {31'b0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    release_op("bp");

    // Flush in DONE drops out_valid even with out_ready low
    out_ready = 1'b0;
    run_op("fl_done", 8'h01, 32'd3, 32'd5, 32'd15);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl_done_ov", {31'b0, out_valid}, 32'd0);
    chk("fl_done_ready", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // Flush at CALC cycle 5
    @(negedge clk);
    in_valid = 1'b1; sel = 8'h08; src1 = 32'hFFFF_FFFF; src2 = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("fl_calc_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    chk("fl_calc_no_ov", 32'(seen), 32'd0);
    run_op("fl_after", 8'h08, 32'h8000_0000, 32'h10, 32'h0000_0008); release_op("fl_after");

    // Flush in IDLE blocks the request
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; sel = 8'h01; src1 = 32'd2; src2 = 32'd2;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("fl_idle_ready", {31'b0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    chk("fl_idle_no_ov", 32'(seen), 32'd0);

    // Asynchronous reset between edges in the middle of CALC
    @(negedge clk);
    in_valid = 1'b1; sel = 8'h02; src1 = 32'h1234_5678; src2 = 32'h9ABC_DEF0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_ready", {31'b0, in_ready}, 32'd1);
    chk("arst_ov", {31'b0, out_valid}, 32'd0);
    chk("arst_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Randomized operations against the reference model
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(0, 9);
      if (r < 8) op = 8'h01 << r;
      else if (r == 8) op = 8'h00;
      else op = 8'($urandom);
      k = $urandom_range(0, 7);
      a = $urandom;
      b = $urandom;
      if (k == 0) b = 32'h0;
      else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (k == 2) begin a = $urandom_range(0, 20); b = $urandom_range(1, 5); end
      else if (k == 3) b = $urandom_range(1, 300);
      e = ref_model(op, a, b);
      run_op("rnd", op, a, b, e);
      release_op("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit for the RV32M extension, parametrised in XLEN.
- Sits beside the single-cycle alu in the execute stage. Uses the same one-hot operation-select style.
- Unlike the combinational alu, it is multi-cycle: radix-2 shift-add multiply or restoring divide, one bit per cycle.
- Valid/ready handshake on input and output, plus a flush input for pipeline kills.

Parameters:
- XLEN, 32, operand and result width in bits (must be 8 or more).
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- src1  in  XLEN  rs1 operand (multiplicand or dividend).
- src2  in  XLEN  rs2 operand (multiplier or divisor).
- sel  in  8  one-hot op select:
  - bit0 MUL, bit1 MULH, bit2 MULHSU, bit3 MULHU.
  - bit4 DIV, bit5 DIVU, bit6 REM, bit7 REMU.
- flush  in  1  abort the current operation.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- result  out  XLEN  operation result.

Behaviour:
- Reset (async, any state): state IDLE, in_ready=1, out_valid=0, result=0, all internal registers 0.
- States:
  - IDLE -> CALC on in_valid&&in_ready. At that edge, latch sel and the magnitudes of src1/src2 per op signedness. Record result sign. Load counter with XLEN.
  - CALC: one iteration per cycle, counter decrements. When counter reaches 1, go to FIX on the next edge.
  - FIX: one cycle. Apply two's-complement sign correction and special cases, then register result. Go to DONE.
  - DONE: out_valid=1, result stable. DONE -> IDLE on out_ready. No new request is accepted in the same cycle, because in_ready is low in DONE.
- Latency: acceptance at edge 0 gives out_valid=1 after edge XLEN+1. Latency is fixed for all ops, including special cases.
- Throughput: at most one op per XLEN+3 cycles when out_ready is held high.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: src1 signed, src2 unsigned.
  - MULHU and DIVU/REMU: both unsigned.
  - DIV/REM: both signed.
- Multiply:
  - Internal product is 2*XLEN bits.
  - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
  - Product sign = XOR of the signs of the signed operands.
- Divide: restoring algorithm on magnitudes.
  - Quotient sign = XOR of operand signs (DIV).
  - Remainder sign = dividend sign (REM).
- Divide by zero (src2==0):
  - DIV/DIVU return all ones.
  - REM/REMU return src1 unchanged.
- Signed overflow (DIV/REM, src1 = 1 followed by XLEN-1 zeros, src2 = all ones):
  - DIV returns src1.
  - REM returns 0.
- Non-one-hot sel (zero or multiple bits set): accepted normally; result = 0 with normal latency.
- flush:
  - Sampled every cycle. Flush=1 in CALC, FIX or DONE forces IDLE at the next edge with out_valid=0; the result register is not updated.
  - Flush in IDLE together with in_valid: the request is not accepted.
  - Flush has priority over out_ready.
- Inputs src1/src2/sel are sampled only at the acceptance edge. Changes during CALC have no effect.
- Result holds its last value in IDLE; it is only observable while out_valid=1.

Test Plan (XLEN=32; src1=0x80000000, src2=0x00000010 unless stated):
- Multiply ops, each with out_ready=1:
  - MUL -> 0x00000000.
  - MULH -> 0xFFFFFFF8.
  - MULHU -> 0x00000008.
  - MULHSU -> 0xFFFFFFF8.
  - out_valid rises exactly 33 edges after acceptance.
- Divide ops:
  - DIVU -> 0x08000000.
  - DIV -> 0xF8000000.
  - REM -> 0x00000000.
  - REMU -> 0x00000000.
  - Also src1=0xFFFFFFF9 (-7), src2=2: DIV -> 0xFFFFFFFD, REM -> 0xFFFFFFFF.
- Special cases:
  - src1=7, src2=0: DIVU -> 0xFFFFFFFF, REMU -> 0x00000007, DIV -> 0xFFFFFFFF.
  - src1=0x80000000, src2=0xFFFFFFFF: DIV -> 0x80000000, REM -> 0x00000000.
  - All with 33-edge latency.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_valid and result stay constant; in_ready stays 0.
  - Raising out_ready gives IDLE next edge, then in_ready=1.
- Flush and reset mid-operation:
  - flush=1 at CALC cycle 5 -> out_valid never asserts; in_ready=1 the next cycle; a following MULHU completes correctly.
  - reset asserted mid-CALC (asynchronous, between edges) -> in_ready=1 and out_valid=0 immediately.
- Invalid sel: sel=0x00 and sel=0x11 -> result 0x00000000 after 33 edges.
